grad_threshold: RTL and testbench
=================================

GRAD_THRESHOLD -- requirements
Module: grad_threshold

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have port: thr_en  input  1  start request; sampled in IDLE only.
REQ-004 SHALL have port: grad_in  input  [3:0][3:0][17:0]  squared gradient magnitudes (gx^2+gy^2) from gradient stage.
REQ-005 SHALL have port: high_thr  input  18  strong-edge threshold, squared units.
REQ-006 SHALL have port: low_thr  input  18  weak-edge threshold, squared units.
REQ-007 SHALL have port: edge_map  output  [3:0][3:0][1:0]  per-pixel class: 00 none, 01 weak, 10 strong; 11 never produced.
REQ-008 SHALL have port: busy  output  1  high from capture through DONE.
REQ-009 SHALL have port: thr_done  output  1  one-cycle pulse; edge_map valid and new.
REQ-010 SHALL have ports strong_cnt, weak_cnt  output  5  each  class counts for last tile (see Configuration).

Function
REQ-011 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-012 IDLE: thr_en=1 at edge N SHALL capture grad_in, high_thr, low_thr into registers, clear index to 0, enter SCAN.
REQ-013 SCAN SHALL classify one element per cycle, index 0..15 row-major (index = row*4+col, element grad_in[row][col]), 16 cycles.
REQ-014 Classification SHALL be: value >= high_thr -> 10; else value >= eff_low -> 01; else 00; comparisons unsigned, full 18 bits.
REQ-015 eff_low SHALL equal min(low_thr, high_thr); low_thr > high_thr therefore yields no weak pixels.
REQ-016 Results SHALL accumulate in an internal working map; edge_map SHALL update atomically on DONE entry (edge N+17), never partially.
REQ-017 DONE SHALL last exactly one cycle with thr_done=1, then return to IDLE at edge N+18.
REQ-018 busy SHALL be 1 in SCAN and DONE, 0 in IDLE.
REQ-019 thr_en while busy SHALL be ignored; no queueing.
REQ-020 thr_en held high SHALL restart immediately from IDLE (next capture at edge N+18).
REQ-021 Input changes after capture SHALL not affect the current tile.
REQ-022 edge_map and counts SHALL hold between tiles.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, index 0, edge_map 0, working map 0, busy 0, thr_done 0, counts 0.
REQ-024 rst during SCAN or DONE SHALL abort the tile; no thr_done pulse; edge_map 0.
REQ-025 rst has priority over thr_en in the same cycle.

Configuration
REQ-026 Macro GRAD_THRESH_COUNT_EN defined: strong_cnt/weak_cnt SHALL count classes per tile, cleared at capture, published with edge_map at DONE entry; range 0..16.
REQ-027 Macro undefined: counters SHALL not be synthesized; strong_cnt and weak_cnt SHALL be tied to 0; all other behaviour identical.

Structure
REQ-028 Package grad_pkg SHALL hold GRAD_W=18, TILE_DIM=4, edge class enum (EDGE_NONE=00, EDGE_WEAK=01, EDGE_STRONG=10), FSM state enum.
REQ-029 Comparator logic SHALL be sub-module grad_classify (value, high, low in; class out, combinational), instantiated once.

Verification
REQ-030 All grad_in 0, high 100, low 50, pulse thr_en -> thr_done at edge N+17, edge_map all 00, counts 0/0.
REQ-031 grad_in[0][0]=2, [1][1]=18, [2][1]=65025, [3][3]=3600; high 3600, low 18 -> [2][1],[3][3]=10; [1][1]=01; rest 00; strong_cnt 2, weak_cnt 1.
REQ-032 All 130050, high 130050, low 0 -> all 10, strong_cnt 16 (equality is strong).
REQ-033 low 5000 > high 1000, values 1500/800 alternating -> 1500 strong, 800 none, weak_cnt 0.
REQ-034 rst asserted at scan cycle 8 -> no thr_done, edge_map 0, busy 0 next cycle; fresh start completes normally.
REQ-035 thr_en pulsed mid-scan with changed grad_in -> ignored; result reflects captured tile; single thr_done.

Source files
------------

// File: rtl/grad_pkg.sv
// grad_pkg: shared widths, tile geometry, edge classes and FSM states for the gradient threshold block.
package grad_pkg;
    localparam int GRAD_W   = 18;
    localparam int TILE_DIM = 4;
    localparam int TILE_N   = TILE_DIM * TILE_DIM;
    typedef enum logic [1:0] {
        EDGE_NONE   = 2'b00,
        EDGE_WEAK   = 2'b01,
        EDGE_STRONG = 2'b10
    } edge_t;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/grad_classify.sv
// grad_classify: combinational strong/weak/none decision for one squared gradient value.
module grad_classify
    import grad_pkg::*;
(
    input  logic [GRAD_W-1:0] value,
    input  logic [GRAD_W-1:0] high,
    input  logic [GRAD_W-1:0] low,
    output edge_t             cls
);
    logic [GRAD_W-1:0] eff_low;
    // A low threshold above the high one collapses the weak band to nothing.
    assign eff_low = (low < high) ? low : high;
    assign cls = (value >= high) ? EDGE_STRONG : (value >= eff_low) ? EDGE_WEAK : EDGE_NONE;
endmodule

// File: rtl/grad_threshold.sv
// grad_threshold: classifies a captured 4x4 tile one pixel per cycle and publishes the map atomically.
// Per-tile class counters are built only when GRAD_THRESH_COUNT_EN is defined; otherwise the counts read 0.
module grad_threshold
    import grad_pkg::*;
(
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        thr_en,
    input  logic [TILE_DIM-1:0][TILE_DIM-1:0][GRAD_W-1:0] grad_in,
    input  logic [GRAD_W-1:0]                           high_thr,
    input  logic [GRAD_W-1:0]                           low_thr,
    output logic [TILE_DIM-1:0][TILE_DIM-1:0][1:0]      edge_map,
    output logic                                        busy,
    output logic                                        thr_done,
    output logic [4:0]                                  strong_cnt,
    output logic [4:0]                                  weak_cnt
);
    state_t                                        state_q;
    logic [4:0]                                    idx_q;
    logic [TILE_DIM-1:0][TILE_DIM-1:0][GRAD_W-1:0] tile_q;
    logic [GRAD_W-1:0]                             high_q;
    logic [GRAD_W-1:0]                             low_q;
    logic [TILE_DIM-1:0][TILE_DIM-1:0][1:0]        work_q;
    logic [TILE_DIM-1:0][TILE_DIM-1:0][1:0]        edge_map_q;
    logic                                          busy_q;
    logic                                          done_q;
    logic                                          start_d;
    logic                                          scan_step_d;
    logic                                          publish_d;
    edge_t                                         cls_d;
    // Leaving DONE with thr_en still high goes straight into the next capture.
    assign start_d     = thr_en && (state_q == IDLE || state_q == DONE);
    assign scan_step_d = (state_q == SCAN) && !idx_q[4];
    assign publish_d   = (state_q == SCAN) && idx_q[4];
    grad_classify u_classify (
        .value (tile_q[idx_q[3:2]][idx_q[1:0]]),
        .high  (high_q),
        .low   (low_q),
        .cls   (cls_d)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            tile_q     <= '0;
            high_q     <= '0;
            low_q      <= '0;
            work_q     <= '0;
            edge_map_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (start_d) begin
            state_q <= SCAN;
            idx_q   <= '0;
            tile_q  <= grad_in;
            high_q  <= high_thr;
            low_q   <= low_thr;
            work_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else if (scan_step_d) begin
            work_q[idx_q[3:2]][idx_q[1:0]] <= cls_d;
            idx_q                          <= idx_q + 5'd1;
        end else if (publish_d) begin
            state_q    <= DONE;
            edge_map_q <= work_q;
            done_q     <= 1'b1;
        end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end
    end
    assign edge_map = edge_map_q;
    assign busy     = busy_q;
    assign thr_done = done_q;
`ifdef GRAD_THRESH_COUNT_EN
    logic [4:0] s_work_q;
    logic [4:0] w_work_q;
    logic [4:0] strong_q;
    logic [4:0] weak_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s_work_q <= '0;
            w_work_q <= '0;
            strong_q <= '0;
            weak_q   <= '0;
        end else if (start_d) begin
            s_work_q <= '0;
            w_work_q <= '0;
        end else if (scan_step_d) begin
            s_work_q <= s_work_q + 5'(cls_d == EDGE_STRONG);
            w_work_q <= w_work_q + 5'(cls_d == EDGE_WEAK);
        end else if (publish_d) begin
            strong_q <= s_work_q;
            weak_q   <= w_work_q;
        end
    end
    assign strong_cnt = strong_q;
    assign weak_cnt   = weak_q;
`else
    assign strong_cnt = '0;
    assign weak_cnt   = '0;
`endif
endmodule

// File: tb/tb_grad_threshold.sv
// tb_grad_threshold: directed checks of grad_threshold timing, classification, reset abort and busy-ignore.
module tb_grad_threshold;
    logic                         clk = 1'b0;
    logic                         rst;
    logic                         thr_en;
    logic [3:0][3:0][17:0]        grad_in;
    logic [17:0]                  high_thr;
    logic [17:0]                  low_thr;
    logic [3:0][3:0][1:0]         edge_map;
    logic                         busy;
    logic                         thr_done;
    logic [4:0]                   strong_cnt;
    logic [4:0]                   weak_cnt;
    logic [3:0][3:0][1:0]         exp_map;
    logic [3:0][3:0][1:0]         pre_map;
    int                           tests = 0;
    int                           fails = 0;
    int                           k;
    int                           extra;

    always #5 clk = ~clk;

    grad_threshold dut (
        .clk        (clk),
        .rst        (rst),
        .thr_en     (thr_en),
        .grad_in    (grad_in),
        .high_thr   (high_thr),
        .low_thr    (low_thr),
        .edge_map   (edge_map),
        .busy       (busy),
        .thr_done   (thr_done),
        .strong_cnt (strong_cnt),
        .weak_cnt   (weak_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] cnt(input int n);
`ifdef GRAD_THRESH_COUNT_EN
        return 5'(n);
`else
        return 5'(0 * n);
`endif
    endfunction

    task automatic start_tile();
        @(negedge clk);
        thr_en = 1'b1;
        @(negedge clk);
        thr_en = 1'b0;
    endtask

    // Counts edges after the call until thr_done shows up; captures the map one edge before.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (thr_done) break;
            pre_map = edge_map;
        end
    endtask

    task automatic after_done(input string tag);
        check({tag, "_busy_in_done"}, busy, 1'b1);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse_end"}, thr_done, 1'b0);
        check({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        thr_en = 1'b0;
        grad_in = '0;
        high_thr = '0;
        low_thr = '0;
        repeat (2) @(negedge clk);
        check("rst_map", edge_map, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", thr_done, 1'b0);
        check("rst_cnt", {strong_cnt, weak_cnt}, 10'h0);
        rst = 1'b0;

        // all-zero tile
        high_thr = 18'd100;
        low_thr = 18'd50;
        start_tile();
        check("zero_busy", busy, 1'b1);
        wait_done(k);
        check("zero_latency", 64'(k - 1 + 2), 64'd17 + 1);
        check("zero_map", edge_map, 32'h0);
        check("zero_cnt", {strong_cnt, weak_cnt}, {cnt(0), cnt(0)});
        after_done("zero");

        // mixed tile
        grad_in = '0;
        grad_in[0][0] = 18'd2;
        grad_in[1][1] = 18'd18;
        grad_in[2][1] = 18'd65025;
        grad_in[3][3] = 18'd3600;
        high_thr = 18'd3600;
        low_thr = 18'd18;
        exp_map = '0;
        exp_map[2][1] = 2'b10;
        exp_map[3][3] = 2'b10;
        exp_map[1][1] = 2'b01;
        start_tile();
        wait_done(k);
        check("mix_latency", 64'(k), 64'd17);
        check("mix_no_partial", pre_map, 32'h0);
        check("mix_map", edge_map, exp_map);
        check("mix_cnt", {strong_cnt, weak_cnt}, {cnt(2), cnt(1)});
        after_done("mix");
        repeat (3) @(negedge clk);
        check("mix_hold", edge_map, exp_map);

        // equality at high threshold is strong
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) grad_in[i][j] = 18'd130050;
        high_thr = 18'd130050;
        low_thr = 18'd0;
        start_tile();
        wait_done(k);
        check("eq_map", edge_map, 32'hAAAA_AAAA);
        check("eq_cnt", {strong_cnt, weak_cnt}, {cnt(16), cnt(0)});
        after_done("eq");

        // low above high: no weak band
        for (int i = 0; i < 16; i++) grad_in[i / 4][i % 4] = (i % 2 == 0) ? 18'd1500 : 18'd800;
        high_thr = 18'd1000;
        low_thr = 18'd5000;
        start_tile();
        wait_done(k);
        check("inv_map", edge_map, 32'h2222_2222);
        check("inv_cnt", {strong_cnt, weak_cnt}, {cnt(8), cnt(0)});
        after_done("inv");

        // reset mid-scan aborts the tile
        start_tile();
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", thr_done, 1'b0);
        check("abort_map", edge_map, 32'h0);
        check("abort_cnt", {strong_cnt, weak_cnt}, 10'h0);
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (thr_done) extra++;
        end
        check("abort_no_pulse", 64'(extra), 64'd0);
        start_tile();
        wait_done(k);
        check("fresh_latency", 64'(k), 64'd17);
        check("fresh_map", edge_map, 32'h2222_2222);
        after_done("fresh");

        // thr_en and new data mid-scan are ignored
        grad_in = '0;
        grad_in[0][0] = 18'd2;
        grad_in[1][1] = 18'd18;
        grad_in[2][1] = 18'd65025;
        grad_in[3][3] = 18'd3600;
        high_thr = 18'd3600;
        low_thr = 18'd18;
        start_tile();
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) grad_in[i][j] = 18'd130050;
        high_thr = 18'd0;
        thr_en = 1'b1;
        @(negedge clk);
        thr_en = 1'b0;
        wait_done(k);
        check("ign_latency", 64'(k), 64'd11);
        check("ign_map", edge_map, exp_map);
        check("ign_cnt", {strong_cnt, weak_cnt}, {cnt(2), cnt(1)});
        extra = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (thr_done) extra++;
        end
        check("ign_single_done", 64'(extra), 64'd0);
        check("ign_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
